// File: rtl/ifetch_pkg.sv
// Shared fetch-stage definitions: datapath width, default queue depth,
// FSM encodings and the queued instruction entry.
package ifetch_pkg;

    localparam int DATA_W   = 16;
    localparam int IF_DEPTH = 2;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } if_entry_t;

    function automatic if_entry_t make_entry(input logic [DATA_W-1:0] addr,
                                             input logic [DATA_W-1:0] data);
        if_entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory request/acknowledge bus between fetch (master) and memory (slave).
interface ifetch_if;
    import ifetch_pkg::*;

    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);

endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of {fetch address, instruction} entries with a
// clear that overrides any same-edge push or pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = IF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  if_entry_t        din,
    output if_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    if_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // A push into a full queue is only legal when the same edge pops.
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: launches one memory request at a time from the PC,
// queues returned words with their address and hands them to decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IF_DEPTH
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] pc_addr,
    input  logic              flush,
    output logic              pc_hold,
    ifetch_if.master          mem,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if_state_e         state_r;
    if_state_e         next_state_s;
    logic              mem_req_r;
    logic              req_next_s;
    logic [DATA_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] addr_next_s;
    logic              launch_s;
    logic              ack_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    if_entry_t         fifo_head_s;

    // Launching only below DEPTH reserves the slot the ack will later fill.
    assign launch_s = (state_r == IF_IDLE) && (fifo_count_s < CNT_W'(DEPTH)) && !flush;
    assign pc_hold  = !launch_s;
    assign ack_s    = mem.mem_ack && mem_req_r;
    assign pop_s    = ir_valid && ir_ready;

    // Next-state and request decode; an issued request is held until acked.
    always_comb begin
        next_state_s = state_r;
        req_next_s   = mem_req_r;
        addr_next_s  = mem_addr_r;
        push_s       = 1'b0;
        case (state_r)
            IF_IDLE: begin
                if (launch_s) begin
                    next_state_s = IF_REQ;
                    req_next_s   = 1'b1;
                    addr_next_s  = pc_addr;
                end else begin
                    next_state_s = IF_IDLE;
                    req_next_s   = 1'b0;
                end
            end
            IF_REQ: begin
                if (ack_s) begin
                    push_s       = !flush;
                    next_state_s = IF_IDLE;
                    req_next_s   = 1'b0;
                end else if (flush) begin
                    next_state_s = IF_DROP;
                end else begin
                    next_state_s = IF_REQ;
                end
            end
            IF_DROP: begin
                if (ack_s) begin
                    next_state_s = IF_IDLE;
                    req_next_s   = 1'b0;
                end else begin
                    next_state_s = IF_DROP;
                end
            end
            default: begin
                next_state_s = IF_IDLE;
                req_next_s   = 1'b0;
            end
        endcase
    end

    // FSM state and registered memory request outputs.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= IF_IDLE;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {DATA_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            mem_req_r  <= req_next_s;
            mem_addr_r <= addr_next_s;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .n_rst (n_rst),
        .push  (push_s),
        .pop   (pop_s),
        .clear (flush),
        .din   (make_entry(mem_addr_r, mem.mem_rdata)),
        .head  (fifo_head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign mem.mem_req  = mem_req_r;
    assign mem.mem_addr = mem_addr_r;
    assign ir_valid     = !fifo_empty_s;
    assign ir           = fifo_head_s.data;
    assign ir_pc        = fifo_head_s.addr;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch; memory returns (address ^ 0xBEEF) as the instruction.
module tb_ifetch;
    import ifetch_pkg::*;

    logic              clock;
    logic              n_rst;
    logic [DATA_W-1:0] pc_addr;
    logic              flush;
    logic              pc_hold;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              ack_tie;
    logic              ack_man;
    int                n_cmp;
    int                n_fail;

    ifetch_if bus ();

    assign bus.mem_rdata = bus.mem_addr ^ 16'hBEEF;
    assign bus.mem_ack   = ack_tie ? bus.mem_req : ack_man;

    ifetch dut (
        .clock    (clock),
        .n_rst    (n_rst),
        .pc_addr  (pc_addr),
        .flush    (flush),
        .pc_hold  (pc_hold),
        .mem      (bus.master),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        n_rst = 1'b0; pc_addr = 16'h0000; flush = 1'b0; ir_ready = 1'b1;
        ack_tie = 1'b1; ack_man = 1'b0;
        #7;
        chk("rst_req", 16'(bus.mem_req), 16'h0000);
        chk("rst_addr", bus.mem_addr, 16'h0000);
        chk("rst_valid", 16'(ir_valid), 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_irpc", ir_pc, 16'h0000);
        @(negedge clock); n_rst = 1'b1; #1;
        chk("c0_hold", 16'(pc_hold), 16'h0000);

        // zero-wait memory, ack tied to request
        @(negedge clock);
        chk("c1_req", 16'(bus.mem_req), 16'h0001);
        chk("c1_addr", bus.mem_addr, 16'h0000);
        chk("c1_hold", 16'(pc_hold), 16'h0001);
        chk("c1_valid", 16'(ir_valid), 16'h0000);
        @(negedge clock);
        chk("c2_valid", 16'(ir_valid), 16'h0001);
        chk("c2_ir", ir, 16'hBEEF);
        chk("c2_irpc", ir_pc, 16'h0000);
        chk("c2_req", 16'(bus.mem_req), 16'h0000);
        chk("c2_hold", 16'(pc_hold), 16'h0000);
        pc_addr = 16'h0010;

        // fill the queue with decode stalled
        @(negedge clock);
        chk("f_req10", 16'(bus.mem_req), 16'h0001);
        chk("f_addr10", bus.mem_addr, 16'h0010);
        chk("f_popped", 16'(ir_valid), 16'h0000);
        ir_ready = 1'b0;
        @(negedge clock);
        chk("f_irpc10", ir_pc, 16'h0010);
        chk("f_hold1", 16'(pc_hold), 16'h0000);
        pc_addr = 16'h0011;
        @(negedge clock);
        chk("f_addr11", bus.mem_addr, 16'h0011);
        @(negedge clock);
        chk("full_hold", 16'(pc_hold), 16'h0001);
        chk("full_req", 16'(bus.mem_req), 16'h0000);
        chk("full_irpc", ir_pc, 16'h0010);
        chk("full_ir", ir, 16'hBEFF);
        pc_addr = 16'h0012;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("stall_hold", 16'(pc_hold), 16'h0001);
            chk("stall_req", 16'(bus.mem_req), 16'h0000);
        end
        ir_ready = 1'b1;
        @(negedge clock);
        chk("pop2_irpc", ir_pc, 16'h0011);
        chk("pop2_ir", ir, 16'hBEFE);
        chk("pop2_hold", 16'(pc_hold), 16'h0000);
        chk("pop2_req", 16'(bus.mem_req), 16'h0000);
        @(negedge clock);
        chk("relaunch_req", 16'(bus.mem_req), 16'h0001);
        chk("relaunch_addr", bus.mem_addr, 16'h0012);
        chk("relaunch_valid", 16'(ir_valid), 16'h0000);
        @(negedge clock);
        chk("p12_valid", 16'(ir_valid), 16'h0001);
        chk("p12_irpc", ir_pc, 16'h0012);
        ack_tie = 1'b0; pc_addr = 16'h0020;

        // three-cycle wait state
        @(negedge clock);
        chk("w1_req", 16'(bus.mem_req), 16'h0001);
        chk("w1_addr", bus.mem_addr, 16'h0020);
        chk("w1_valid", 16'(ir_valid), 16'h0000);
        pc_addr = 16'h0021;
        @(negedge clock);
        chk("w2_req", 16'(bus.mem_req), 16'h0001);
        chk("w2_addr", bus.mem_addr, 16'h0020);
        @(negedge clock);
        chk("w3_req", 16'(bus.mem_req), 16'h0001);
        chk("w3_addr", bus.mem_addr, 16'h0020);
        ack_man = 1'b1; pc_addr = 16'h0030;
        @(negedge clock);
        ack_man = 1'b0;
        chk("w_ack_req", 16'(bus.mem_req), 16'h0000);
        chk("w_ack_valid", 16'(ir_valid), 16'h0001);
        chk("w_ack_irpc", ir_pc, 16'h0020);
        chk("w_ack_ir", ir, 16'hBECF);

        // flush during a wait -> DROP
        @(negedge clock);
        chk("one_push", 16'(ir_valid), 16'h0000);
        chk("d1_addr", bus.mem_addr, 16'h0030);
        pc_addr = 16'h0100;
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("drop_req", 16'(bus.mem_req), 16'h0001);
        chk("drop_addr", bus.mem_addr, 16'h0030);
        chk("drop_hold", 16'(pc_hold), 16'h0001);
        @(negedge clock);
        chk("drop2_req", 16'(bus.mem_req), 16'h0001);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        chk("dropped_req", 16'(bus.mem_req), 16'h0000);
        chk("dropped_valid", 16'(ir_valid), 16'h0000);
        chk("dropped_hold", 16'(pc_hold), 16'h0000);
        @(negedge clock);
        chk("redir_addr", bus.mem_addr, 16'h0100);
        chk("redir_req", 16'(bus.mem_req), 16'h0001);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        chk("redir_irpc", ir_pc, 16'h0100);
        chk("redir_ir", ir, 16'hBFEF);
        ir_ready = 1'b0; pc_addr = 16'h0200;

        // flush coinciding with ack and pop
        @(negedge clock);
        chk("fap_addr", bus.mem_addr, 16'h0200);
        chk("fap_valid", 16'(ir_valid), 16'h0001);
        ack_man = 1'b1; ir_ready = 1'b1; flush = 1'b1;
        @(negedge clock);
        chk("fap_valid0", 16'(ir_valid), 16'h0000);
        chk("fap_req0", 16'(bus.mem_req), 16'h0000);
        chk("fap_hold", 16'(pc_hold), 16'h0001);
        flush = 1'b0; ack_man = 1'b0; ir_ready = 1'b0; pc_addr = 16'h0300;
        @(negedge clock);
        chk("f300_addr", bus.mem_addr, 16'h0300);
        chk("f300_valid", 16'(ir_valid), 16'h0000);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0; pc_addr = 16'h0301;
        @(negedge clock);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        chk("ff_hold", 16'(pc_hold), 16'h0001);
        chk("ff_irpc", ir_pc, 16'h0300);
        chk("ff_ir", ir, 16'hBDEF);
        flush = 1'b1; ir_ready = 1'b1;

        // flush with a full queue and pop
        @(negedge clock);
        chk("ffl_valid", 16'(ir_valid), 16'h0000);
        chk("ffl_req", 16'(bus.mem_req), 16'h0000);
        flush = 1'b0; ir_ready = 1'b0; pc_addr = 16'h0400;
        @(negedge clock);
        chk("r_addr", bus.mem_addr, 16'h0400);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        chk("r_valid", 16'(ir_valid), 16'h0001);
        @(negedge clock);
        chk("r_req", 16'(bus.mem_req), 16'h0001);

        // asynchronous reset in the middle of a request
        #2 n_rst = 1'b0;
        #1;
        chk("ar_req", 16'(bus.mem_req), 16'h0000);
        chk("ar_valid", 16'(ir_valid), 16'h0000);
        chk("ar_addr", bus.mem_addr, 16'h0000);
        chk("ar_irpc", ir_pc, 16'h0000);
        chk("ar_hold", 16'(pc_hold), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
